go_done_initiator: RTL and testbench

- Requester side of the go/done handshake used by the counting datapath.
- On a `start` request it runs a batch of NUM_JOBS jobs. For each job it raises `go`, waits for `done`, captures the datapath's `count`, then waits for `done` to fall before issuing the next job.
- Accumulates a saturating sum of the captured counts and flags jobs that time out.
- Sits between the board-level control (buttons/switches) and the datapath, replacing the manual `go` stimulus.

---
 rtl/go_done_pkg.sv | 27 ++
 rtl/go_done_timeout_ctr.sv | 29 ++
 rtl/go_done_initiator.sv | 156 +++++++++++++++
 tb/tb_go_done_initiator.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/go_done_pkg.sv
// Shared types and helpers for the go/done requester.
// State encoding, default datapath widths and the saturating adder.
package go_done_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ASSERT_GO = 3'd1,
    WAIT_DONE = 3'd2,
    CAPTURE   = 3'd3,
    WAIT_LOW  = 3'd4
  } state_t;

  localparam int DEF_COUNT_W = 7;
  localparam int DEF_SUM_W   = 10;

  // Unsigned a+b clamped to 2^w-1; valid for w up to 31.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/go_done_timeout_ctr.sv
// Per-job watchdog: counts cycles while enabled, flags TIMEOUT-1.
// Clear has priority over enable; the count parks at the terminal value.
module go_done_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == TC_VAL);
  assign o_tc = w_tc;

  // Cycle counter with synchronous clear; holds once terminal.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)            r_cnt <= '0;
    else if (i_clr)          r_cnt <= '0;
    else if (i_en && !w_tc)  r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/go_done_initiator.sv
// Requester side of the four-phase go/done handshake.
// Runs NUM_JOBS jobs per start, sums captured counts with saturation,
// and aborts the batch if a job stays in WAIT_DONE for TIMEOUT cycles.
// Optional: define GO_DONE_MAX_TRACK_EN to add the max_count output.
module go_done_initiator
  import go_done_pkg::*;
#(
  parameter int COUNT_W  = DEF_COUNT_W,
  parameter int SUM_W    = DEF_SUM_W,
  parameter int NUM_JOBS = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               start,
  output logic               go,
  input  logic               done,
  input  logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] last_count,
  output logic [SUM_W-1:0]   sum,
  output logic               result_valid,
  output logic [7:0]         job_idx,
  output logic               busy,
  output logic               batch_done,
`ifdef GO_DONE_MAX_TRACK_EN
  output logic               timeout_err,
  output logic [COUNT_W-1:0] max_count
`else
  output logic               timeout_err
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_JOBS - 1);

  state_t             r_state;
  logic               r_go;
  logic [COUNT_W-1:0] r_last_count;
  logic [SUM_W-1:0]   r_sum;
  logic               r_result_valid;
  logic [7:0]         r_job_idx;
  logic               r_busy;
  logic               r_batch_done;
  logic               r_timeout_err;
`ifdef GO_DONE_MAX_TRACK_EN
  logic [COUNT_W-1:0] r_max_count;
`endif

  logic             w_to_clr;
  logic             w_to_en;
  logic             w_to_tc;
  logic [SUM_W-1:0] w_sum_next;

  // Watchdog only runs while waiting for done; any other state rearms it.
  assign w_to_en  = (r_state == WAIT_DONE);
  assign w_to_clr = (r_state != WAIT_DONE);

  assign w_sum_next = SUM_W'(sat_add(32'(r_sum), 32'(count), SUM_W));

  go_done_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk   (Clk),
    .i_rst_n (Rst),
    .i_clr   (w_to_clr),
    .i_en    (w_to_en),
    .o_tc    (w_to_tc)
  );

  // Batch sequencer; every output is a register updated here.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state        <= IDLE;
      r_go           <= 1'b0;
      r_last_count   <= '0;
      r_sum          <= '0;
      r_result_valid <= 1'b0;
      r_job_idx      <= '0;
      r_busy         <= 1'b0;
      r_batch_done   <= 1'b0;
      r_timeout_err  <= 1'b0;
`ifdef GO_DONE_MAX_TRACK_EN
      r_max_count    <= '0;
`endif
    end else begin
      r_result_valid <= 1'b0;
      r_batch_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state       <= ASSERT_GO;
            r_job_idx     <= '0;
            r_sum         <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b1;
`ifdef GO_DONE_MAX_TRACK_EN
            r_max_count   <= '0;
`endif
          end
        end
        ASSERT_GO: begin
          // done is deliberately not looked at here: a stale high done
          // is only accepted once we are in WAIT_DONE.
          r_go    <= 1'b1;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            r_last_count   <= count;
            r_sum          <= w_sum_next;
            r_go           <= 1'b0;
            r_result_valid <= 1'b1;
            r_state        <= CAPTURE;
          end else if (w_to_tc) begin
            r_go          <= 1'b0;
            r_timeout_err <= 1'b1;
            r_batch_done  <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end
        end
        CAPTURE: begin
`ifdef GO_DONE_MAX_TRACK_EN
          if (r_last_count > r_max_count) r_max_count <= r_last_count;
`endif
          r_state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!done) begin
            if (r_job_idx == LAST_IDX) begin
              r_batch_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= IDLE;
            end else begin
              r_job_idx <= r_job_idx + 8'd1;
              r_state   <= ASSERT_GO;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign go           = r_go;
  assign last_count   = r_last_count;
  assign sum          = r_sum;
  assign result_valid = r_result_valid;
  assign job_idx      = r_job_idx;
  assign busy         = r_busy;
  assign batch_done   = r_batch_done;
  assign timeout_err  = r_timeout_err;
`ifdef GO_DONE_MAX_TRACK_EN
  assign max_count    = r_max_count;
`endif

endmodule

// File: tb/tb_go_done_initiator.sv
// Scoreboard bench for go_done_initiator: stimulus pushes expected
// captures/batch ends into queues, monitors pop them on result_valid
// and batch_done. A second instance (NUM_JOBS=9) covers saturation.
module tb_go_done_initiator;

  typedef struct {
    logic [6:0] lc;
    logic [9:0] sm;
    logic [7:0] idx;
  } res_t;

  typedef struct {
    logic       terr;
    logic [9:0] sm;
  } bd_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic [6:0] count = '0;
  logic       go;
  logic [6:0] last_count;
  logic [9:0] sum;
  logic       result_valid;
  logic [7:0] job_idx;
  logic       busy;
  logic       batch_done;
  logic       timeout_err;

  logic       start_s = 1'b0;
  logic       done_s = 1'b0;
  logic [6:0] count_s = 7'd127;
  logic       go_s;
  logic [6:0] last_count_s;
  logic [9:0] sum_s;
  logic       result_valid_s;
  logic [7:0] job_idx_s;
  logic       busy_s;
  logic       batch_done_s;
  logic       timeout_err_s;

`ifdef GO_DONE_MAX_TRACK_EN
  logic [6:0] max_count;
  logic [6:0] max_count_s;
`endif

  res_t       q_res[$];
  bd_t        q_bd[$];
  logic [9:0] q_sat[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         sat_bd = 0;

  always #5 Clk = ~Clk;

  go_done_initiator #(.COUNT_W(7), .SUM_W(10), .NUM_JOBS(4), .TIMEOUT(64)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .go(go), .done(done), .count(count),
    .last_count(last_count), .sum(sum), .result_valid(result_valid),
    .job_idx(job_idx), .busy(busy), .batch_done(batch_done),
`ifdef GO_DONE_MAX_TRACK_EN
    .timeout_err(timeout_err), .max_count(max_count)
`else
    .timeout_err(timeout_err)
`endif
  );

  go_done_initiator #(.COUNT_W(7), .SUM_W(10), .NUM_JOBS(9), .TIMEOUT(16)) dut_s (
    .Clk(Clk), .Rst(Rst), .start(start_s), .go(go_s), .done(done_s), .count(count_s),
    .last_count(last_count_s), .sum(sum_s), .result_valid(result_valid_s),
    .job_idx(job_idx_s), .busy(busy_s), .batch_done(batch_done_s),
`ifdef GO_DONE_MAX_TRACK_EN
    .timeout_err(timeout_err_s), .max_count(max_count_s)
`else
    .timeout_err(timeout_err_s)
`endif
  );

  // Saturation responder: done follows go one cycle later.
  always @(posedge Clk) done_s <= go_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Main-instance monitor.
  always @(negedge Clk) begin : mon_main
    res_t r;
    bd_t  b;
    if (result_valid) begin
      if (q_res.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result_valid: got last_count=%0d sum=%0d, want none", last_count, sum);
      end else begin
        r = q_res.pop_front();
        chk("res_last_count", 32'(last_count), 32'(r.lc));
        chk("res_sum", 32'(sum), 32'(r.sm));
        chk("res_job_idx", 32'(job_idx), 32'(r.idx));
      end
    end
    if (batch_done) begin
      if (q_bd.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_batch_done: got sum=%0d, want none", sum);
      end else begin
        b = q_bd.pop_front();
        chk("bd_timeout_err", 32'(timeout_err), 32'(b.terr));
        chk("bd_sum", 32'(sum), 32'(b.sm));
        chk("bd_busy", 32'(busy), 32'd0);
      end
    end
  end

  // Saturation-instance monitor.
  always @(negedge Clk) begin : mon_sat
    logic [9:0] e;
    if (result_valid_s) begin
      if (q_sat.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_sat_result: got sum=%0d, want none", sum_s);
      end else begin
        e = q_sat.pop_front();
        chk("sat_sum", 32'(sum_s), 32'(e));
        chk("sat_last_count", 32'(last_count_s), 32'd127);
      end
    end
    if (batch_done_s) begin
      sat_bd++;
      chk("sat_bd_sum", 32'(sum_s), 32'd1023);
    end
  end

  task automatic wait_go(input logic lvl, input string nm);
    int n = 0;
    while (go !== lvl && n < 300) begin @(posedge Clk); #1; n++; end
    if (go !== lvl) begin
      n_total++;
      $display("FAIL %s: go=%0b, want %0b within 300 cycles", nm, go, lvl);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin @(posedge Clk); #1; n++; end
    if (busy !== 1'b0) begin
      n_total++;
      $display("FAIL %s: busy=%0b, want 0 within 500 cycles", nm, busy);
    end
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1 start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
  endtask

  // Responder: done 5 cycles after go, dropped 2 cycles after go falls.
  task automatic job_normal(input logic [6:0] c);
    wait_go(1'b1, "job_go_rise");
    repeat (5) @(posedge Clk);
    #1 done = 1'b1; count = c;
    wait_go(1'b0, "job_go_fall");
    repeat (2) @(posedge Clk);
    #1 done = 1'b0; count = '0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    // Reset / idle
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    chk("rst_go", 32'(go), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_last_count", 32'(last_count), 0);
    chk("rst_job_idx", 32'(job_idx), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_flags", 32'({result_valid, batch_done}), 0);
`ifdef GO_DONE_MAX_TRACK_EN
    chk("rst_max_count", 32'(max_count), 0);
`endif
    done = 1'b1; count = 7'd99;
    repeat (5) begin
      @(posedge Clk); #1;
      chk("idle_done_ignored", 32'({result_valid, busy, go}), 0);
    end
    done = 1'b0; count = '0;

    // Nominal batch 10,20,30,40
    q_res.push_back('{7'd10, 10'd10, 8'd0});
    q_res.push_back('{7'd20, 10'd30, 8'd1});
    q_res.push_back('{7'd30, 10'd60, 8'd2});
    q_res.push_back('{7'd40, 10'd100, 8'd3});
    q_bd.push_back('{1'b0, 10'd100});
    pulse_start();
    chk("nom_go_after_1", 32'(go), 0);
    chk("nom_busy", 32'(busy), 1);
    @(posedge Clk); #1;
    chk("nom_go_after_2", 32'(go), 1);
    job_normal(7'd10);
    job_normal(7'd20);
    job_normal(7'd30);
`ifdef GO_DONE_MAX_TRACK_EN
    chk("nom_max_after_job2", 32'(max_count), 30);
`endif
    job_normal(7'd40);
    wait_idle("nom_idle");
    chk("nom_last_count", 32'(last_count), 40);
    chk("nom_sum", 32'(sum), 100);
    chk("nom_timeout_err", 32'(timeout_err), 0);
    chk("nom_go_low", 32'(go), 0);
`ifdef GO_DONE_MAX_TRACK_EN
    chk("nom_max_final", 32'(max_count), 40);
`endif

    // Timeout: responder silent
    q_bd.push_back('{1'b1, 10'd0});
    pulse_start();
    @(posedge Clk); #1;
    chk("to_go_rise", 32'(go), 1);
    n = 1;
    while (n < 300) begin
      @(posedge Clk); #1;
      if (go) n++;
      else break;
    end
    chk("to_go_high_cycles", 32'(n), 64);
    chk("to_timeout_err", 32'(timeout_err), 1);
    chk("to_busy", 32'(busy), 0);
    repeat (3) @(posedge Clk); #1;
    chk("to_err_sticky", 32'(timeout_err), 1);

    // Handshake edges: done high before start, held after capture
    done = 1'b1; count = 7'd5;
    q_res.push_back('{7'd5, 10'd5, 8'd0});
    q_res.push_back('{7'd1, 10'd6, 8'd1});
    q_res.push_back('{7'd2, 10'd8, 8'd2});
    q_res.push_back('{7'd3, 10'd11, 8'd3});
    q_bd.push_back('{1'b0, 10'd11});
    pulse_start();
    chk("hs_err_cleared", 32'(timeout_err), 0);
    wait_go(1'b1, "hs_go_rise");
    wait_go(1'b0, "hs_go_fall");
    repeat (10) begin
      @(posedge Clk); #1;
      chk("hs_go_held_low", 32'({go, busy}), 32'b01);
    end
    done = 1'b0; count = '0;
    job_normal(7'd1);
    job_normal(7'd2);
    job_normal(7'd3);
    wait_idle("hs_idle");
    chk("hs_sum", 32'(sum), 11);

    // Reset during WAIT_DONE of job 2
    q_res.push_back('{7'd7, 10'd7, 8'd0});
    q_res.push_back('{7'd8, 10'd15, 8'd1});
    pulse_start();
    job_normal(7'd7);
    job_normal(7'd8);
    wait_go(1'b1, "mid_go_rise");
    chk("mid_job_idx", 32'(job_idx), 2);
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(posedge Clk); #1;
    chk("mid_go", 32'(go), 0);
    chk("mid_sum", 32'(sum), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_last_count", 32'(last_count), 0);
`ifdef GO_DONE_MAX_TRACK_EN
    chk("mid_max_count", 32'(max_count), 0);
`endif
    Rst = 1'b1;
    repeat (2) @(posedge Clk); #1;
    chk("mid_stays_idle", 32'({go, busy}), 0);

    // Saturation on the 9-job instance
    q_sat.push_back(10'd127);  q_sat.push_back(10'd254);  q_sat.push_back(10'd381);
    q_sat.push_back(10'd508);  q_sat.push_back(10'd635);  q_sat.push_back(10'd762);
    q_sat.push_back(10'd889);  q_sat.push_back(10'd1016); q_sat.push_back(10'd1023);
    @(posedge Clk); #1 start_s = 1'b1;
    @(posedge Clk); #1 start_s = 1'b0;
    n = 0;
    while (busy_s !== 1'b0 && n < 500) begin @(posedge Clk); #1; n++; end
    if (busy_s !== 1'b0) begin
      n_total++;
      $display("FAIL sat_idle: busy_s=%0b, want 0 within 500 cycles", busy_s);
    end
    chk("sat_sum_final", 32'(sum_s), 1023);
    chk("sat_timeout_err", 32'(timeout_err_s), 0);
    repeat (3) @(posedge Clk); #1;

    chk("q_res_drained", 32'(q_res.size()), 0);
    chk("q_bd_drained", 32'(q_bd.size()), 0);
    chk("q_sat_drained", 32'(q_sat.size()), 0);
    chk("sat_batch_done_count", 32'(sat_bd), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
